// File: rtl/paddle_pkg.sv
// Shared definitions for the paddle bounding-box tracker: colour indices,
// FSM state encoding and a per-colour bounding-box record.
package paddle_pkg;

  localparam int C1_IDX      = 1;
  localparam int C2_IDX      = 0;
  localparam int NUM_COLOURS = 2;

  localparam int BOX_COORD_WIDTH = 13;
  localparam int BOX_INDEX_WIDTH = 19;

  typedef enum logic {
    ACCUM   = 1'b0,
    PUBLISH = 1'b1
  } state_t;

  typedef struct packed {
    logic [BOX_COORD_WIDTH-1:0] min_col;
    logic [BOX_COORD_WIDTH-1:0] max_col;
    logic [BOX_COORD_WIDTH-1:0] min_row;
    logic [BOX_COORD_WIDTH-1:0] max_row;
    logic [BOX_INDEX_WIDTH-1:0] count;
  } bbox_t;

endpackage

// File: rtl/paddle_bbox_tracker_bbox_accum.sv
// Single-colour accumulator: live count/bounding box plus a snapshot that
// captures the live state merged with the current pixel.
module bbox_accum #(
  parameter int COORD_WIDTH = 13,
  parameter int INDEX_WIDTH = 19
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_hit,
  input  logic                   i_snap,
  input  logic                   i_clear,
  input  logic [COORD_WIDTH-1:0] i_row,
  input  logic [COORD_WIDTH-1:0] i_col,
  output logic [INDEX_WIDTH-1:0] o_count,
  output logic [COORD_WIDTH-1:0] o_min_col,
  output logic [COORD_WIDTH-1:0] o_max_col,
  output logic [COORD_WIDTH-1:0] o_min_row,
  output logic [COORD_WIDTH-1:0] o_max_row
);

  logic [INDEX_WIDTH-1:0] r_count, w_count;
  logic [COORD_WIDTH-1:0] r_min_col, r_max_col, r_min_row, r_max_row;
  logic [COORD_WIDTH-1:0] w_min_col, w_max_col, w_min_row, w_max_row;
  logic [INDEX_WIDTH-1:0] r_snap_count;
  logic [COORD_WIDTH-1:0] r_snap_min_col, r_snap_max_col, r_snap_min_row, r_snap_max_row;

  // Live state merged with the current pixel; the count saturates.
  always_comb begin
    w_count   = r_count;
    w_min_col = r_min_col;
    w_max_col = r_max_col;
    w_min_row = r_min_row;
    w_max_row = r_max_row;
    if (i_hit) begin
      if (r_count != '1) w_count = r_count + INDEX_WIDTH'(1);
      if (i_col < r_min_col) w_min_col = i_col;
      if (i_col > r_max_col) w_max_col = i_col;
      if (i_row < r_min_row) w_min_row = i_row;
      if (i_row > r_max_row) w_max_row = i_row;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count        <= '0;
      r_min_col      <= '1;
      r_max_col      <= '0;
      r_min_row      <= '1;
      r_max_row      <= '0;
      r_snap_count   <= '0;
      r_snap_min_col <= '0;
      r_snap_max_col <= '0;
      r_snap_min_row <= '0;
      r_snap_max_row <= '0;
    end else begin
      if (i_clear) begin
        r_count   <= '0;
        r_min_col <= '1;
        r_max_col <= '0;
        r_min_row <= '1;
        r_max_row <= '0;
      end else begin
        r_count   <= w_count;
        r_min_col <= w_min_col;
        r_max_col <= w_max_col;
        r_min_row <= w_min_row;
        r_max_row <= w_max_row;
      end
      if (i_snap) begin
        r_snap_count   <= w_count;
        r_snap_min_col <= w_min_col;
        r_snap_max_col <= w_max_col;
        r_snap_min_row <= w_min_row;
        r_snap_max_row <= w_max_row;
      end
    end
  end

  assign o_count   = r_snap_count;
  assign o_min_col = r_snap_min_col;
  assign o_max_col = r_snap_max_col;
  assign o_min_row = r_snap_min_row;
  assign o_max_row = r_snap_max_row;

endmodule

// File: rtl/paddle_bbox_tracker.sv
// Per-frame two-colour paddle tracker: raster counters, ACCUM/PUBLISH FSM
// and formatting of per-colour box, centre, count and found flag.
module paddle_bbox_tracker
  import paddle_pkg::*;
#(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int COORD_WIDTH = 13,
  parameter int INDEX_WIDTH = 19,
  parameter int MIN_PIXELS  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [1:0]                 color_enc,
  output logic                       out_valid,
  output logic [1:0]                 found,
  output logic [2*INDEX_WIDTH-1:0]   count,
  output logic [2*COORD_WIDTH-1:0]   min_col,
  output logic [2*COORD_WIDTH-1:0]   max_col,
  output logic [2*COORD_WIDTH-1:0]   min_row,
  output logic [2*COORD_WIDTH-1:0]   max_row,
  output logic [2*COORD_WIDTH-1:0]   ctr_col,
  output logic [2*COORD_WIDTH-1:0]   ctr_row,
  output logic                       frame_done
);

  logic [COORD_WIDTH-1:0] r_col, r_row;
  state_t                 r_state;
  logic                   r_out_valid, r_frame_done;
  logic                   w_col_wrap, w_last;

  assign w_col_wrap = (r_col == COORD_WIDTH'(WIDTH - 1));
  assign w_last     = in_valid && w_col_wrap && (r_row == COORD_WIDTH'(HEIGHT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col        <= '0;
      r_row        <= '0;
      r_state      <= ACCUM;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last;
      r_out_valid  <= (r_state == PUBLISH);
      if (in_valid) begin
        if (w_col_wrap) begin
          r_col <= '0;
          r_row <= (r_row == COORD_WIDTH'(HEIGHT - 1)) ? '0 : r_row + COORD_WIDTH'(1);
        end else begin
          r_col <= r_col + COORD_WIDTH'(1);
        end
      end
      case (r_state)
        ACCUM:   if (w_last) r_state <= PUBLISH;
        PUBLISH: r_state <= ACCUM;
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;

  for (genvar gi = 0; gi < NUM_COLOURS; gi++) begin : g_colour
    logic [INDEX_WIDTH-1:0] w_snap_count;
    logic [COORD_WIDTH-1:0] w_snap_min_col, w_snap_max_col, w_snap_min_row, w_snap_max_row;
    logic                   w_found;
    logic [COORD_WIDTH-1:0] w_ctr_col, w_ctr_row;
    logic                   r_found;
    logic [INDEX_WIDTH-1:0] r_count;
    logic [COORD_WIDTH-1:0] r_min_col, r_max_col, r_min_row, r_max_row, r_ctr_col, r_ctr_row;

    // The snapshot and the live clear share the last-pixel strobe.
    bbox_accum #(
      .COORD_WIDTH (COORD_WIDTH),
      .INDEX_WIDTH (INDEX_WIDTH)
    ) u_accum (
      .clk       (clk),
      .reset     (reset),
      .i_hit     (in_valid & color_enc[gi]),
      .i_snap    (w_last),
      .i_clear   (w_last),
      .i_row     (r_row),
      .i_col     (r_col),
      .o_count   (w_snap_count),
      .o_min_col (w_snap_min_col),
      .o_max_col (w_snap_max_col),
      .o_min_row (w_snap_min_row),
      .o_max_row (w_snap_max_row)
    );

    assign w_found   = (w_snap_count >= INDEX_WIDTH'(MIN_PIXELS));
    assign w_ctr_col = COORD_WIDTH'(({1'b0, w_snap_min_col} + {1'b0, w_snap_max_col}) >> 1);
    assign w_ctr_row = COORD_WIDTH'(({1'b0, w_snap_min_row} + {1'b0, w_snap_max_row}) >> 1);

    always_ff @(posedge clk) begin
      if (reset) begin
        r_found   <= 1'b0;
        r_count   <= '0;
        r_min_col <= '0;
        r_max_col <= '0;
        r_min_row <= '0;
        r_max_row <= '0;
        r_ctr_col <= '0;
        r_ctr_row <= '0;
      end else if (r_state == PUBLISH) begin
        r_found   <= w_found;
        r_count   <= w_snap_count;
        r_min_col <= w_found ? w_snap_min_col : '0;
        r_max_col <= w_found ? w_snap_max_col : '0;
        r_min_row <= w_found ? w_snap_min_row : '0;
        r_max_row <= w_found ? w_snap_max_row : '0;
        r_ctr_col <= w_found ? w_ctr_col : '0;
        r_ctr_row <= w_found ? w_ctr_row : '0;
      end
    end

    assign found[gi]                            = r_found;
    assign count[gi*INDEX_WIDTH +: INDEX_WIDTH] = r_count;
    assign min_col[gi*COORD_WIDTH +: COORD_WIDTH] = r_min_col;
    assign max_col[gi*COORD_WIDTH +: COORD_WIDTH] = r_max_col;
    assign min_row[gi*COORD_WIDTH +: COORD_WIDTH] = r_min_row;
    assign max_row[gi*COORD_WIDTH +: COORD_WIDTH] = r_max_row;
    assign ctr_col[gi*COORD_WIDTH +: COORD_WIDTH] = r_ctr_col;
    assign ctr_row[gi*COORD_WIDTH +: COORD_WIDTH] = r_ctr_row;
  end

endmodule

// File: tb/tb_paddle_bbox_tracker.sv
// Randomised bench for paddle_bbox_tracker against a frame-level model that
// tracks hits by pixel index and predicts publish contents and timing.
module tb_paddle_bbox_tracker;
  import paddle_pkg::*;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int MINP = 2;
  localparam int CW   = 13;
  localparam int IW   = 19;
  localparam int NPIX = W * H;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic [1:0]      color_enc = 2'b00;
  logic            out_valid, frame_done;
  logic [1:0]      found;
  logic [2*IW-1:0] count;
  logic [2*CW-1:0] min_col, max_col, min_row, max_row, ctr_col, ctr_row;

  paddle_bbox_tracker #(
    .WIDTH       (W),
    .HEIGHT      (H),
    .COORD_WIDTH (CW),
    .INDEX_WIDTH (IW),
    .MIN_PIXELS  (MINP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .color_enc  (color_enc),
    .out_valid  (out_valid),
    .found      (found),
    .count      (count),
    .min_col    (min_col),
    .max_col    (max_col),
    .min_row    (min_row),
    .max_row    (max_row),
    .ctr_col    (ctr_col),
    .ctr_row    (ctr_row),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int              cyc;
    logic [1:0]      found;
    logic [2*IW-1:0] count;
    logic [2*CW-1:0] min_col, max_col, min_row, max_row, ctr_col, ctr_row;
  } exp_t;

  exp_t       exp_q[$];
  int         fd_q[$];
  bbox_t      acc[2];
  int         pix;
  logic [1:0] frame_map[NPIX];
  exp_t       mon_e;
  exp_t       last_e;
  int         n_frames = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    pix = 0;
    for (int k = 0; k < 2; k++) begin
      acc[k].count   = '0;
      acc[k].min_col = '1;
      acc[k].max_col = '0;
      acc[k].min_row = '1;
      acc[k].max_row = '0;
    end
  endtask

  // Frame result from the accumulated hits; the accepting edge makes cyc+1.
  task automatic model_publish();
    exp_t e;
    e.cyc = cyc + 2;
    e.found = '0;
    e.count = '0;
    e.min_col = '0; e.max_col = '0; e.min_row = '0; e.max_row = '0;
    e.ctr_col = '0; e.ctr_row = '0;
    for (int k = 0; k < 2; k++) begin
      e.count[k*IW +: IW] = acc[k].count;
      if (int'(acc[k].count) >= MINP) begin
        e.found[k] = 1'b1;
        e.min_col[k*CW +: CW] = acc[k].min_col;
        e.max_col[k*CW +: CW] = acc[k].max_col;
        e.min_row[k*CW +: CW] = acc[k].min_row;
        e.max_row[k*CW +: CW] = acc[k].max_row;
        e.ctr_col[k*CW +: CW] = CW'((int'(acc[k].min_col) + int'(acc[k].max_col)) / 2);
        e.ctr_row[k*CW +: CW] = CW'((int'(acc[k].min_row) + int'(acc[k].max_row)) / 2);
      end
    end
    exp_q.push_back(e);
    fd_q.push_back(cyc + 1);
  endtask

  task automatic model_accept(input logic [1:0] enc);
    int r, c;
    r = pix / W;
    c = pix % W;
    for (int k = 0; k < 2; k++) begin
      if (enc[k]) begin
        acc[k].count = acc[k].count + 1;
        if (c < int'(acc[k].min_col)) acc[k].min_col = CW'(c);
        if (c > int'(acc[k].max_col)) acc[k].max_col = CW'(c);
        if (r < int'(acc[k].min_row)) acc[k].min_row = CW'(r);
        if (r > int'(acc[k].max_row)) acc[k].max_row = CW'(r);
      end
    end
    pix++;
    if (pix == NPIX) begin
      model_publish();
      model_clear();
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] enc);
    @(negedge clk);
    in_valid  = v;
    color_enc = enc;
    if (v) model_accept(enc);
  endtask

  task automatic send_frame(input int gap_pct);
    for (int i = 0; i < NPIX; i++) begin
      while ($urandom_range(99) < gap_pct) drive(1'b0, 2'($urandom_range(3)));
      drive(1'b1, frame_map[i]);
    end
  endtask

  task automatic clear_map();
    for (int i = 0; i < NPIX; i++) frame_map[i] = 2'b00;
  endtask

  task automatic random_map();
    for (int i = 0; i < NPIX; i++)
      frame_map[i] = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'b0;
    color_enc = 2'b00;
    model_clear();
    exp_q.delete();
    fd_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Publish and frame_done monitor.
  always @(negedge clk) begin
    if (!reset) begin
      logic exp_ov, exp_fd;
      exp_fd = (fd_q.size() > 0) && (fd_q[0] == cyc);
      if (frame_done || exp_fd) check("frame_done", 64'(frame_done), 64'(exp_fd));
      if (exp_fd) void'(fd_q.pop_front());
      exp_ov = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      if (out_valid || exp_ov) check("out_valid", 64'(out_valid), 64'(exp_ov));
      if (exp_ov) begin
        mon_e = exp_q.pop_front();
        last_e = mon_e;
        n_frames++;
        $display("[TB] frame %0d published at cycle %0d: found=%b count=%0h", n_frames, cyc, found, count);
        if (out_valid) begin
          check("found",   64'(found),   64'(mon_e.found));
          check("count",   64'(count),   64'(mon_e.count));
          check("min_col", 64'(min_col), 64'(mon_e.min_col));
          check("max_col", 64'(max_col), 64'(mon_e.max_col));
          check("min_row", 64'(min_row), 64'(mon_e.min_row));
          check("max_row", 64'(max_row), 64'(mon_e.max_row));
          check("ctr_col", 64'(ctr_col), 64'(mon_e.ctr_col));
          check("ctr_row", 64'(ctr_row), 64'(mon_e.ctr_row));
        end
      end
    end
  end

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid",  64'(out_valid),  64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    check("rst_found",      64'(found),      64'(0));
    check("rst_count",      64'(count),      64'(0));
    check("rst_min_col",    64'(min_col),    64'(0));
    check("rst_max_row",    64'(max_row),    64'(0));
    check("rst_ctr_col",    64'(ctr_col),    64'(0));

    // Directed frames, back to back so pixels land in PUBLISH.
    clear_map();
    send_frame(0);
    clear_map();
    frame_map[1*W + 2] = 2'b10;
    frame_map[2*W + 5] = 2'b10;
    frame_map[1*W + 6] = 2'b10;
    send_frame(0);
    clear_map();
    frame_map[0]        = 2'b11;
    frame_map[3*W + 7]  = 2'b11;
    send_frame(0);
    clear_map();
    frame_map[2*W + 2] = 2'b01;
    send_frame(0);

    // Random masks with random valid gaps.
    for (int f = 0; f < 4; f++) begin
      random_map();
      send_frame((f % 2 == 0) ? 50 : 0);
    end

    // Reset in mid-frame at pixel (2,3) after hits.
    for (int i = 0; i < 2*W + 3; i++) drive(1'b1, 2'b11);
    do_reset();
    random_map();
    frame_map[0] = 2'b01;
    frame_map[NPIX-1] = 2'b01;
    send_frame(30);

    repeat (8) drive(1'b0, 2'b00);
    check("drained", 64'(exp_q.size()), 64'(0));
    check("hold_count", 64'(count), 64'(last_e.count));
    check("hold_found", 64'(found), 64'(last_e.found));
    check("frames_seen", 64'(n_frames), 64'(9));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
